// File: rtl/verifier_sumcheck_rounds_pkg.sv
// Shared prime-field definitions (Mersenne q = 2^61-1) and the round-engine state type,
// reused by the verifier FSMs.
package verifier_sumcheck_rounds_pkg;

    localparam int F_NBITS = 61;
    localparam logic [F_NBITS-1:0] F_Q = {F_NBITS{1'b1}};
    // q-2: exponent for inversion by Fermat exponentiation
    localparam logic [F_NBITS-1:0] F_Q_P2_MI = F_Q - 61'd2;

    typedef logic [F_NBITS-1:0] felem_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_SUM,
        ST_HORN,
        ST_STORE,
        ST_DONE
    } sc_state_t;

    function automatic felem_t f_add(input felem_t a, input felem_t b);
        logic [F_NBITS:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, F_Q}) s = s - {1'b0, F_Q};
        return s[F_NBITS-1:0];
    endfunction

    function automatic felem_t f_sub(input felem_t a, input felem_t b);
        logic [F_NBITS:0] s;
        s = {1'b0, a} + {1'b0, F_Q} - {1'b0, b};
        if (s >= {1'b0, F_Q}) s = s - {1'b0, F_Q};
        return s[F_NBITS-1:0];
    endfunction

    // Folding reduction; only valid because q is a Mersenne prime.
    function automatic felem_t f_mul_reduce(input logic [2*F_NBITS-1:0] p);
        logic [F_NBITS:0] t;
        felem_t t2;
        t  = {1'b0, p[F_NBITS-1:0]} + {1'b0, p[2*F_NBITS-1:F_NBITS]};
        t2 = t[F_NBITS-1:0] + {{(F_NBITS-1){1'b0}}, t[F_NBITS]};
        if (t2 == F_Q) t2 = '0;
        return t2;
    endfunction

endpackage

// File: rtl/field_horner_eval.sv
// Serial Horner evaluation of c0 + c1*x + ... + c_deg*x^deg with one shared multiplier.
// ready is high while idle; result is valid whenever ready is high.
module field_horner_eval
    import verifier_sumcheck_rounds_pkg::*;
#(
    parameter int NCOEF = 4,
    parameter int DEG_W = $clog2(NCOEF)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [DEG_W-1:0]         deg,
    input  logic [NCOEF*F_NBITS-1:0] coef,
    input  logic [F_NBITS-1:0]       x,
    output logic                     ready,
    output logic [F_NBITS-1:0]       result
);

    typedef enum logic {H_IDLE, H_BUSY} h_state_t;

    h_state_t         state_reg;
    felem_t           coef_in [NCOEF];
    felem_t           coef_reg [NCOEF];
    felem_t           acc_reg;
    felem_t           x_reg;
    logic [DEG_W-1:0] k_reg;
    logic [DEG_W-1:0] k_dec;
    logic             mul_en_reg;
    logic             ready_reg;
    logic             mul_ready;
    felem_t           mul_result;

    generate
        for (genvar gi = 0; gi < NCOEF; gi++) begin : g_unpack
            assign coef_in[gi] = coef[gi*F_NBITS +: F_NBITS];
        end
    endgenerate

    assign k_dec = k_reg - DEG_W'(1);

    field_multiplier u_mul (
        .clk    (clk),
        .rst    (rst),
        .en     (mul_en_reg),
        .a      (acc_reg),
        .b      (x_reg),
        .ready  (mul_ready),
        .result (mul_result)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= H_IDLE;
            acc_reg    <= '0;
            x_reg      <= '0;
            k_reg      <= '0;
            mul_en_reg <= 1'b0;
            ready_reg  <= 1'b1;
            for (int i = 0; i < NCOEF; i++) coef_reg[i] <= '0;
        end else begin
            case (state_reg)
                H_IDLE: begin
                    if (start) begin
                        coef_reg <= coef_in;
                        acc_reg  <= coef_in[deg];
                        x_reg    <= x;
                        k_reg    <= deg;
                        // a constant polynomial needs no multiply at all
                        if (deg != '0) begin
                            mul_en_reg <= 1'b1;
                            ready_reg  <= 1'b0;
                            state_reg  <= H_BUSY;
                        end
                    end
                end
                H_BUSY: begin
                    mul_en_reg <= 1'b0;
                    if (mul_ready) begin
                        acc_reg <= f_add(mul_result, coef_reg[k_dec]);
                        k_reg   <= k_dec;
                        if (k_dec == '0) begin
                            ready_reg <= 1'b1;
                            state_reg <= H_IDLE;
                        end else begin
                            mul_en_reg <= 1'b1;
                        end
                    end
                end
                default: state_reg <= H_IDLE;
            endcase
        end
    end

    assign ready  = ready_reg;
    assign result = acc_reg;

endmodule

// File: rtl/field_multiplier.sv
// Two-stage pipelined modular multiplier: raw product, then reduction.
// ready pulses with result two cycles after en.
module field_multiplier
    import verifier_sumcheck_rounds_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [F_NBITS-1:0] a,
    input  logic [F_NBITS-1:0] b,
    output logic               ready,
    output logic [F_NBITS-1:0] result
);

    logic [2*F_NBITS-1:0] prod_reg;
    logic                 prod_valid_reg;
    felem_t               result_reg;
    logic                 ready_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            prod_reg       <= '0;
            prod_valid_reg <= 1'b0;
            result_reg     <= '0;
            ready_reg      <= 1'b0;
        end else begin
            prod_reg       <= a * b;
            prod_valid_reg <= en;
            result_reg     <= f_mul_reduce(prod_reg);
            ready_reg      <= prod_valid_reg;
        end
    end

    assign ready  = ready_reg;
    assign result = result_reg;

endmodule

// File: rtl/verifier_sumcheck_rounds.sv
// Verifier sum-check round engine for one layer: per round checks p(0)+p(1) against the
// running claim, evaluates p(r) as the next claim and records the challenge.
module verifier_sumcheck_rounds
    import verifier_sumcheck_rounds_pkg::*;
#(
    parameter int nCopyBits = 3,
    parameter int nInBits   = 3,
    parameter int nDegCopy  = 3,
    parameter int nDegIn    = 2,
    localparam int nRounds  = nCopyBits + 2 * nInBits,
    localparam int nCoef    = ((nDegCopy > nDegIn) ? nDegCopy : nDegIn) + 1,
    localparam int IDX_W    = $clog2(nRounds + 1),
    localparam int DEG_W    = $clog2(nCoef)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [F_NBITS-1:0]           claim_in,
    input  logic                         rnd_valid,
    output logic                         rnd_ready,
    input  logic [nCoef*F_NBITS-1:0]     coef,
    input  logic [F_NBITS-1:0]           chal,
    output logic [nCopyBits*F_NBITS-1:0] w3_vals,
    output logic [nInBits*F_NBITS-1:0]   w1_vals,
    output logic [nInBits*F_NBITS-1:0]   w2_vals,
    output logic [F_NBITS-1:0]           final_claim,
    output logic [IDX_W-1:0]             rnd_idx,
    output logic                         done,
    output logic                         fail
);

    localparam logic [DEG_W-1:0] DEG_COPY = DEG_W'(nDegCopy);
    localparam logic [DEG_W-1:0] DEG_IN   = DEG_W'(nDegIn);

    sc_state_t              state_reg;
    logic [nCoef*F_NBITS-1:0] coef_reg;
    felem_t                 coef_a [nCoef];
    felem_t                 chal_reg, claim_reg, sum_reg, acc_reg, final_reg;
    felem_t                 w3_reg [nCopyBits];
    felem_t                 w1_reg [nInBits];
    felem_t                 w2_reg [nInBits];
    logic [DEG_W-1:0]       deg_reg, sum_idx_reg;
    logic [IDX_W-1:0]       rnd_idx_reg;
    logic                   rnd_ready_reg, done_reg, fail_reg;
    felem_t                 sum_step;
    logic                   sum_last, horn_start, horn_ready;
    felem_t                 horn_result;

    generate
        for (genvar gi = 0; gi < nCoef; gi++) begin : g_coef
            assign coef_a[gi] = coef_reg[gi*F_NBITS +: F_NBITS];
        end
        for (genvar gi = 0; gi < nCopyBits; gi++) begin : g_w3
            assign w3_vals[gi*F_NBITS +: F_NBITS] = w3_reg[gi];
        end
        for (genvar gi = 0; gi < nInBits; gi++) begin : g_w12
            assign w1_vals[gi*F_NBITS +: F_NBITS] = w1_reg[gi];
            assign w2_vals[gi*F_NBITS +: F_NBITS] = w2_reg[gi];
        end
    endgenerate

    // s = 2*c0 + c1 + ... + cD, one add per SUM cycle
    always_comb begin
        sum_step = f_add(sum_reg, coef_a[sum_idx_reg]);
        if (sum_idx_reg == '0) sum_step = f_add(coef_a[0], coef_a[0]);
    end

    assign sum_last   = (state_reg == ST_SUM) && (sum_idx_reg == deg_reg);
    assign horn_start = sum_last && (sum_step == claim_reg);

    field_horner_eval #(.NCOEF(nCoef), .DEG_W(DEG_W)) u_horner (
        .clk    (clk),
        .rst    (rst),
        .start  (horn_start),
        .deg    (deg_reg),
        .coef   (coef_reg),
        .x      (chal_reg),
        .ready  (horn_ready),
        .result (horn_result)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            coef_reg      <= '0;
            chal_reg      <= '0;
            claim_reg     <= '0;
            sum_reg       <= '0;
            acc_reg       <= '0;
            final_reg     <= '0;
            deg_reg       <= '0;
            sum_idx_reg   <= '0;
            rnd_idx_reg   <= '0;
            rnd_ready_reg <= 1'b0;
            done_reg      <= 1'b0;
            fail_reg      <= 1'b0;
            for (int i = 0; i < nCopyBits; i++) w3_reg[i] <= '0;
            for (int i = 0; i < nInBits; i++) begin
                w1_reg[i] <= '0;
                w2_reg[i] <= '0;
            end
        end else begin
            case (state_reg)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        claim_reg     <= claim_in;
                        rnd_idx_reg   <= '0;
                        fail_reg      <= 1'b0;
                        done_reg      <= 1'b0;
                        rnd_ready_reg <= 1'b1;
                        state_reg     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (rnd_valid) begin
                        coef_reg      <= coef;
                        chal_reg      <= chal;
                        deg_reg       <= (rnd_idx_reg < IDX_W'(nCopyBits)) ? DEG_COPY : DEG_IN;
                        sum_idx_reg   <= '0;
                        rnd_ready_reg <= 1'b0;
                        state_reg     <= ST_SUM;
                    end
                end
                ST_SUM: begin
                    sum_reg     <= sum_step;
                    sum_idx_reg <= sum_idx_reg + DEG_W'(1);
                    if (sum_last) begin
                        if (sum_step == claim_reg) begin
                            state_reg <= ST_HORN;
                        end else begin
                            fail_reg  <= 1'b1;
                            done_reg  <= 1'b1;
                            state_reg <= ST_DONE;
                        end
                    end
                end
                ST_HORN: begin
                    if (horn_ready) begin
                        acc_reg   <= horn_result;
                        state_reg <= ST_STORE;
                    end
                end
                ST_STORE: begin
                    claim_reg <= acc_reg;
                    for (int i = 0; i < nCopyBits; i++)
                        if (rnd_idx_reg == IDX_W'(i)) w3_reg[i] <= chal_reg;
                    for (int i = 0; i < nInBits; i++) begin
                        if (rnd_idx_reg == IDX_W'(nCopyBits + i)) w1_reg[i] <= chal_reg;
                        if (rnd_idx_reg == IDX_W'(nCopyBits + nInBits + i)) w2_reg[i] <= chal_reg;
                    end
                    rnd_idx_reg <= rnd_idx_reg + IDX_W'(1);
                    if (rnd_idx_reg == IDX_W'(nRounds - 1)) begin
                        final_reg <= acc_reg;
                        done_reg  <= 1'b1;
                        state_reg <= ST_DONE;
                    end else begin
                        rnd_ready_reg <= 1'b1;
                        state_reg     <= ST_WAIT;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign rnd_ready   = rnd_ready_reg;
    assign final_claim = final_reg;
    assign rnd_idx     = rnd_idx_reg;
    assign done        = done_reg;
    assign fail        = fail_reg;

endmodule

// File: tb/tb_verifier_sumcheck_rounds.sv
// Directed bench for verifier_sumcheck_rounds with one copy round and one w1/w2 round each.
module tb_verifier_sumcheck_rounds;
    import verifier_sumcheck_rounds_pkg::*;

    localparam int NCOEF = 4;
    localparam felem_t Q = F_Q;

    logic                     clk = 1'b0;
    logic                     rst, start, rnd_valid, rnd_ready, done, fail;
    logic [F_NBITS-1:0]       claim_in, chal, final_claim;
    logic [NCOEF*F_NBITS-1:0] coef;
    logic [F_NBITS-1:0]       w3_vals, w1_vals, w2_vals;
    logic [1:0]               rnd_idx;

    int n_pass  = 0;
    int n_total = 0;

    verifier_sumcheck_rounds #(
        .nCopyBits(1), .nInBits(1), .nDegCopy(3), .nDegIn(2)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .claim_in(claim_in),
        .rnd_valid(rnd_valid), .rnd_ready(rnd_ready), .coef(coef), .chal(chal),
        .w3_vals(w3_vals), .w1_vals(w1_vals), .w2_vals(w2_vals),
        .final_claim(final_claim), .rnd_idx(rnd_idx), .done(done), .fail(fail)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    function automatic logic [NCOEF*F_NBITS-1:0] pk(input felem_t c0, input felem_t c1,
                                                   input felem_t c2, input felem_t c3);
        return {c3, c2, c1, c0};
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic start_pulse(input felem_t c);
        claim_in = c;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!rnd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", {63'd0, rnd_ready}, 64'd1);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("done_wait", {63'd0, done}, 64'd1);
    endtask

    // Presents a round after 'gap' cycles of junk with rnd_valid low; returns after accept edge.
    task automatic do_round(input logic [NCOEF*F_NBITS-1:0] cv, input felem_t r, input int gap);
        wait_ready();
        for (int g = 0; g < gap; g++) begin
            for (int i = 0; i < NCOEF; i++)
                coef[i*F_NBITS +: F_NBITS] = F_NBITS'({$urandom, $urandom});
            chal = F_NBITS'({$urandom, $urandom});
            @(negedge clk);
        end
        coef      = cv;
        chal      = r;
        rnd_valid = 1'b1;
        @(negedge clk);
        rnd_valid = 1'b0;
        coef      = pk(7, 7, 7, 7);
        chal      = 61'd9;
    endtask

    task automatic run_nominal(input int gap, input string tag);
        start_pulse(61'd10);
        do_round(pk(3, 2, 1, 1), 61'd2, gap);
        do_round(pk(5, 4, 5, 99), 61'd3, gap);
        do_round(pk(20, 10, 12, 99), 61'd1, gap);
        wait_done();
        check({tag, "_fail"}, {63'd0, fail}, 64'd0);
        check({tag, "_final"}, {3'd0, final_claim}, 64'd42);
        check({tag, "_w3"}, {3'd0, w3_vals}, 64'd2);
        check({tag, "_w1"}, {3'd0, w1_vals}, 64'd3);
        check({tag, "_w2"}, {3'd0, w2_vals}, 64'd1);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; rnd_valid = 1'b0;
        claim_in = '0; chal = '0; coef = '0;
        repeat (3) @(negedge clk);
        check("rst_ready", {63'd0, rnd_ready}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_fail", {63'd0, fail}, 64'd0);
        check("rst_idx", {62'd0, rnd_idx}, 64'd0);
        check("rst_final", {3'd0, final_claim}, 64'd0);
        check("rst_w", {3'd0, w3_vals | w1_vals | w2_vals}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Nominal three rounds with intermediate checks
        start_pulse(61'd10);
        do_round(pk(3, 2, 1, 1), 61'd2, 0);
        wait_ready();
        check("s1_r0_w3", {3'd0, w3_vals}, 64'd2);
        check("s1_r0_idx", {62'd0, rnd_idx}, 64'd1);
        do_round(pk(5, 4, 5, 99), 61'd3, 0);
        wait_ready();
        check("s1_r1_w1", {3'd0, w1_vals}, 64'd3);
        do_round(pk(20, 10, 12, 99), 61'd1, 0);
        wait_done();
        check("s1_fail", {63'd0, fail}, 64'd0);
        check("s1_final", {3'd0, final_claim}, 64'd42);
        check("s1_w2", {3'd0, w2_vals}, 64'd1);
        check("s1_idx", {62'd0, rnd_idx}, 64'd3);
        check("s1_ready", {63'd0, rnd_ready}, 64'd0);

        // Sum mismatch on R1: 2*6+4+5 = 21 != 19
        do_reset();
        start_pulse(61'd10);
        do_round(pk(3, 2, 1, 1), 61'd2, 0);
        do_round(pk(6, 4, 5, 0), 61'd3, 0);
        wait_done();
        check("s2_fail", {63'd0, fail}, 64'd1);
        check("s2_w1", {3'd0, w1_vals}, 64'd0);
        check("s2_w3", {3'd0, w3_vals}, 64'd2);
        check("s2_idx", {62'd0, rnd_idx}, 64'd1);
        check("s2_final", {3'd0, final_claim}, 64'd0);
        repeat (5) @(negedge clk);
        check("s2_no_r2", {63'd0, rnd_ready}, 64'd0);

        // Restart from DONE; modular wrap: claims 0 -> q-3 -> q-1 -> q-5
        start_pulse(61'd0);
        check("s3_fail_clr", {63'd0, fail}, 64'd0);
        check("s3_done_clr", {63'd0, done}, 64'd0);
        do_round(pk(Q - 61'd1, 61'd2, 61'd0, 61'd0), Q - 61'd1, 0);
        do_round(pk(Q - 61'd1, Q - 61'd1, 61'd0, 61'd0), 61'd0, 0);
        do_round(pk(61'd0, Q - 61'd1, 61'd0, 61'd0), 61'd5, 0);
        wait_done();
        check("s3_fail", {63'd0, fail}, 64'd0);
        check("s3_final", {3'd0, final_claim}, {3'd0, Q - 61'd5});
        check("s3_w3", {3'd0, w3_vals}, {3'd0, Q - 61'd1});
        check("s3_w2", {3'd0, w2_vals}, 64'd5);

        // Backpressure with junk inputs while rnd_valid is low
        do_reset();
        run_nominal(5, "s4");

        // Reset during HORN of R1, then a clean run
        do_reset();
        start_pulse(61'd10);
        do_round(pk(3, 2, 1, 1), 61'd2, 0);
        do_round(pk(5, 4, 5, 99), 61'd3, 0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("s5_w3", {3'd0, w3_vals}, 64'd0);
        check("s5_idx", {62'd0, rnd_idx}, 64'd0);
        check("s5_flags", {61'd0, rnd_ready, done, fail}, 64'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("s5_idle", {63'd0, rnd_ready}, 64'd0);
        run_nominal(0, "s5");

        // start pulsed while R0 is in SUM must be ignored
        do_reset();
        start_pulse(61'd10);
        do_round(pk(3, 2, 1, 1), 61'd2, 0);
        start_pulse(61'd77);
        do_round(pk(5, 4, 5, 99), 61'd3, 0);
        do_round(pk(20, 10, 12, 99), 61'd1, 0);
        wait_done();
        check("s6_fail", {63'd0, fail}, 64'd0);
        check("s6_final", {3'd0, final_claim}, 64'd42);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
